ram_port_arbiter: RTL and testbench
===================================

// Module: ram_port_arbiter
// PURPOSE
//  Two-requestor front end for ram_single_port: port 0 (fetch), port 1 (load/store).
//  Accepts one valid/ready request per cycle and drives the RAM's single port that cycle.
//  Adds byte-strobe writes by read-merge against the RAM's combinational dout.
//  Returns read data through a one-entry response buffer per port.
// PARAMETERS
//  ADDR_WIDTH  16  word address width; must equal the RAM's ADDR_WIDTH
//  DATA_WIDTH  32  word width; multiple of 8; STRB_W = DATA_WIDTH/8
// PORTS
//  clk            in   1           single clock, rising edge
//  rst_n          in   1           asynchronous reset, active-low
//  pN_req_valid   in   1           N=0,1: request present
//  pN_req_ready   out  1           request accepted when valid&ready at posedge
//  pN_req_we      in   1           1=write, 0=read
//  pN_req_addr    in   ADDR_WIDTH  word address
//  pN_req_wdata   in   DATA_WIDTH  write data
//  pN_req_wstrb   in   STRB_W      byte enables; write only
//  pN_rsp_valid   out  1           read data available
//  pN_rsp_ready   in   1           consumer takes read data
//  pN_rsp_rdata   out  DATA_WIDTH  read data
//  ram_we         out  1           to RAM we
//  ram_addr       out  ADDR_WIDTH  to RAM addr
//  ram_din        out  DATA_WIDTH  to RAM din
//  ram_dout       in   DATA_WIDTH  from RAM dout (combinational read)
// BEHAVIOUR
//  - Reset (rst_n=0, async): pN_rsp_valid=0, pN_rsp_rdata=0, last_grant=1;
//    pN_req_ready=0 and ram_we=0 while rst_n=0.
//  - eligible_N = pN_req_valid & (pN_req_we | ~rsp_full_N | pN_rsp_ready).
//    Read blocked only while port's buffer full and not drained the same cycle.
//  - Grant: at most one port per cycle, combinational. Only one eligible -> it.
//    Both eligible -> arbitration policy (CONFIGURATION). pN_req_ready = grant_N.
//  - No grant: ram_we=0, ram_addr=p0_req_addr, ram_din=ram_dout (idle, no write).
//  - Granted read: ram_addr=addr, ram_we=0; ram_dout captured into port's buffer
//    at posedge; rsp_valid=1 next cycle (latency 1). Buffer holds until rsp_ready.
//  - Simultaneous drain+fill: new data loaded, rsp_valid stays 1 (back-to-back OK,
//    full throughput one read/cycle per port).
//  - Granted write: ram_we=1, ram_addr=addr,
//    ram_din[8b+7:8b] = wstrb[b] ? wdata[8b+7:8b] : ram_dout[8b+7:8b].
//    Completes on handshake; no response. wstrb=0 is a legal no-op write.
//  - last_grant updated to the granted port on each handshake only.
//  - Reset mid-transaction: buffered responses discarded; in-flight write either
//    committed (edge before reset) or not; no partial state retained.
//  - Inputs must be stable while valid&~ready (standard valid/ready rules).
// CONFIGURATION
//  RAM_ARB_RR_EN defined: round-robin; on conflict grant port != last_grant.
//  RAM_ARB_RR_EN undefined: fixed priority, port 0 always wins conflicts;
//    last_grant still maintained but unused.
// TESTING
//  1 Reset: rst_n=0 mid-cycle with p0 read pending -> p0_rsp_valid=0,
//    ram_we=0 immediately; after release p0 read to 0x0010 served in 1 cycle.
//  2 Strobe write: RAM[0x0004]=0xAABBCCDD; p1 write 0x11223344, wstrb=4'b0101
//    -> RAM[0x0004]=0xAA22CC44; then p1 read -> p1_rsp_rdata=0xAA22CC44 next cycle.
//  3 Conflict: both ports valid reads for 4 cycles -> RR: grants 0,1,0,1;
//    no RR: grants 0,0,0,0 with p1_req_ready=0 throughout.
//  4 Backpressure: p0_rsp_ready=0, two p0 reads -> first accepted, second
//    ready=0 until rsp_ready=1; that cycle second accepted, data not lost.
//  5 Streaming: p0 reads 0x0000..0x0007, rsp_ready=1 -> 8 rsp_valid beats,
//    consecutive, rdata in address order, 1-cycle latency each.
//  6 Write/read mix: p1 write while p0 read buffer full -> write still granted.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Two-port valid/ready front end for a single-port RAM with byte-strobe writes (read-merge)
// and a one-entry read response buffer per port. Define RAM_ARB_RR_EN for round-robin arbitration.
module ram_port_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    p0_req_valid,
    output logic                    p0_req_ready,
    input  logic                    p0_req_we,
    input  logic [ADDR_WIDTH-1:0]   p0_req_addr,
    input  logic [DATA_WIDTH-1:0]   p0_req_wdata,
    input  logic [DATA_WIDTH/8-1:0] p0_req_wstrb,
    output logic                    p0_rsp_valid,
    input  logic                    p0_rsp_ready,
    output logic [DATA_WIDTH-1:0]   p0_rsp_rdata,
    input  logic                    p1_req_valid,
    output logic                    p1_req_ready,
    input  logic                    p1_req_we,
    input  logic [ADDR_WIDTH-1:0]   p1_req_addr,
    input  logic [DATA_WIDTH-1:0]   p1_req_wdata,
    input  logic [DATA_WIDTH/8-1:0] p1_req_wstrb,
    output logic                    p1_rsp_valid,
    input  logic                    p1_rsp_ready,
    output logic [DATA_WIDTH-1:0]   p1_rsp_rdata,
    output logic                    ram_we,
    output logic [ADDR_WIDTH-1:0]   ram_addr,
    output logic [DATA_WIDTH-1:0]   ram_din,
    input  logic [DATA_WIDTH-1:0]   ram_dout
);

    localparam int STRB_W = DATA_WIDTH / 8;

    function automatic logic [DATA_WIDTH-1:0] strobe_merge(
        input logic [DATA_WIDTH-1:0] wdata,
        input logic [DATA_WIDTH-1:0] old,
        input logic [STRB_W-1:0]     strb
    );
        logic [DATA_WIDTH-1:0] merged;
        merged = old;
        for (int b = 0; b < STRB_W; b++) begin
            if (strb[b]) begin
                merged[8*b +: 8] = wdata[8*b +: 8];
            end else begin
                merged[8*b +: 8] = old[8*b +: 8];
            end
        end
        return merged;
    endfunction

    logic [1:0]            rsp_full_r;
    logic [DATA_WIDTH-1:0] rsp_data_r [2];
    logic                  last_grant_r;

    logic [1:0]            eligible_s;
    logic [1:0]            grant_s;
    logic [1:0]            rd_fill_s;
    logic [1:0]            rsp_ready_s;
    logic                  sel_we_s;
    logic [ADDR_WIDTH-1:0] sel_addr_s;
    logic [DATA_WIDTH-1:0] sel_wdata_s;
    logic [STRB_W-1:0]     sel_strb_s;

    // A read is only held off while its buffer is full and not being drained this cycle.
    assign eligible_s[0] = p0_req_valid & (p0_req_we | ~rsp_full_r[0] | p0_rsp_ready);
    assign eligible_s[1] = p1_req_valid & (p1_req_we | ~rsp_full_r[1] | p1_rsp_ready);
    assign rsp_ready_s   = {p1_rsp_ready, p0_rsp_ready};
    assign rd_fill_s     = grant_s & ~{p1_req_we, p0_req_we};

    assign p0_req_ready  = grant_s[0];
    assign p1_req_ready  = grant_s[1];
    assign p0_rsp_valid  = rsp_full_r[0];
    assign p1_rsp_valid  = rsp_full_r[1];
    assign p0_rsp_rdata  = rsp_data_r[0];
    assign p1_rsp_rdata  = rsp_data_r[1];

    // Grant selection; nothing is granted while reset is asserted.
    always_comb begin
        grant_s = 2'b00;
        if (!rst_n) begin
            grant_s = 2'b00;
        end else begin
            case (eligible_s)
                2'b01:   grant_s = 2'b01;
                2'b10:   grant_s = 2'b10;
`ifdef RAM_ARB_RR_EN
                2'b11:   grant_s = last_grant_r ? 2'b01 : 2'b10;
`else
                // last_grant is still tracked, but fixed priority always picks port 0
                2'b11:   grant_s = last_grant_r ? 2'b01 : 2'b01;
`endif
                default: grant_s = 2'b00;
            endcase
        end
    end

    // Request fields of the port that owns the RAM this cycle (port 0 when idle).
    always_comb begin
        sel_we_s    = p0_req_we;
        sel_addr_s  = p0_req_addr;
        sel_wdata_s = p0_req_wdata;
        sel_strb_s  = p0_req_wstrb;
        if (grant_s[1]) begin
            sel_we_s    = p1_req_we;
            sel_addr_s  = p1_req_addr;
            sel_wdata_s = p1_req_wdata;
            sel_strb_s  = p1_req_wstrb;
        end else begin
            sel_we_s    = p0_req_we;
            sel_addr_s  = p0_req_addr;
            sel_wdata_s = p0_req_wdata;
            sel_strb_s  = p0_req_wstrb;
        end
    end

    // RAM port drive; idle cycles rewrite nothing because we stays low.
    always_comb begin
        ram_addr = sel_addr_s;
        ram_we   = 1'b0;
        ram_din  = ram_dout;
        if (grant_s != 2'b00) begin
            ram_we  = sel_we_s;
            ram_din = sel_we_s ? strobe_merge(sel_wdata_s, ram_dout, sel_strb_s) : ram_dout;
        end else begin
            ram_we  = 1'b0;
            ram_din = ram_dout;
        end
    end

    // Response buffers: fill wins over drain so back-to-back reads stream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_full_r    <= 2'b00;
            rsp_data_r[0] <= {DATA_WIDTH{1'b0}};
            rsp_data_r[1] <= {DATA_WIDTH{1'b0}};
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (rd_fill_s[n]) begin
                    rsp_full_r[n] <= 1'b1;
                    rsp_data_r[n] <= ram_dout;
                end else if (rsp_ready_s[n]) begin
                    rsp_full_r[n] <= 1'b0;
                end else begin
                    rsp_full_r[n] <= rsp_full_r[n];
                end
            end
        end
    end

    // Remember which port won the most recent handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_r <= 1'b1;
        end else if (grant_s != 2'b00) begin
            last_grant_r <= grant_s[1];
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: behavioural RAM, vector table, directed
// corner sequences and a randomized run against a queue-based reference model.
module tb_ram_port_arbiter;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int SW = 4;
`ifdef RAM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          p0_req_valid, p0_req_ready, p0_req_we, p0_rsp_valid, p0_rsp_ready;
    logic [AW-1:0] p0_req_addr;
    logic [DW-1:0] p0_req_wdata, p0_rsp_rdata;
    logic [SW-1:0] p0_req_wstrb;
    logic          p1_req_valid, p1_req_ready, p1_req_we, p1_rsp_valid, p1_rsp_ready;
    logic [AW-1:0] p1_req_addr;
    logic [DW-1:0] p1_req_wdata, p1_rsp_rdata;
    logic [SW-1:0] p1_req_wstrb;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din, ram_dout;

    int checks = 0;
    int errors = 0;

    ram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_we(p0_req_we),
        .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata), .p0_req_wstrb(p0_req_wstrb),
        .p0_rsp_valid(p0_rsp_valid), .p0_rsp_ready(p0_rsp_ready), .p0_rsp_rdata(p0_rsp_rdata),
        .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_we(p1_req_we),
        .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata), .p1_req_wstrb(p1_req_wstrb),
        .p1_rsp_valid(p1_rsp_valid), .p1_rsp_ready(p1_rsp_ready), .p1_rsp_rdata(p1_rsp_rdata),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM with combinational read, plus bench load/poke hooks.
    logic [DW-1:0] ram_mem [256];
    logic          init_req = 1'b0;
    logic [31:0]   init_seed = 32'd0;
    logic          poke_en = 1'b0;
    logic [7:0]    poke_addr = 8'd0;
    logic [DW-1:0] poke_data = 32'd0;
    assign ram_dout = ram_mem[ram_addr[7:0]];

    function automatic logic [DW-1:0] init_word(input int i, input logic [31:0] seed);
        logic [7:0] b;
        b = i[7:0];
        return (seed * 32'h9E3779B1) ^ ({24'd0, b} * 32'h01010101) ^ 32'h5A00_0000;
    endfunction

    always @(posedge clk) begin
        if (init_req) begin
            for (int i = 0; i < 256; i++) ram_mem[i] <= init_word(i, init_seed);
        end else if (poke_en) begin
            ram_mem[poke_addr] <= poke_data;
        end else if (ram_we) begin
            ram_mem[ram_addr[7:0]] <= ram_din;
        end
    end

    // Reference model state
    logic [DW-1:0] model_mem [256];
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    int            model_last;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] wd, input logic [DW-1:0] old,
                                            input logic [SW-1:0] st);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < SW; b++) if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        p0_req_valid = 1'b0; p0_req_we = 1'b0; p0_req_addr = 16'h0000;
        p0_req_wdata = 32'h0; p0_req_wstrb = 4'h0; p0_rsp_ready = 1'b1;
        p1_req_valid = 1'b0; p1_req_we = 1'b0; p1_req_addr = 16'h0000;
        p1_req_wdata = 32'h0; p1_req_wstrb = 4'h0; p1_rsp_ready = 1'b1;
    endtask

    task automatic init_mem(input logic [31:0] seed);
        init_seed = seed;
        init_req  = 1'b1;
        @(posedge clk);
        #1 init_req = 1'b0;
        for (int i = 0; i < 256; i++) model_mem[i] = init_word(i, seed);
        @(negedge clk);
    endtask

    task automatic poke(input logic [7:0] a, input logic [DW-1:0] d);
        poke_addr = a; poke_data = d; poke_en = 1'b1;
        @(posedge clk);
        #1 poke_en = 1'b0;
        model_mem[a] = d;
        @(negedge clk);
    endtask

    typedef struct {
        logic v0; logic we0; logic [15:0] a0;
        logic v1; logic we1; logic [15:0] a1;
        logic r0; logic r1; logic rwe; logic [15:0] raddr;
    } vec_t;
    vec_t tbl [7];

    logic          pv [2];
    logic          pw [2];
    logic [15:0]   pa [2];
    logic [DW-1:0] pd [2];
    logic [SW-1:0] ps [2];
    logic          rr [2];
    logic          acc [2];
    logic          el [2];
    int            g;
    logic [DW-1:0] mdat;

    initial begin
        tbl[0] = '{1'b0, 1'b0, 16'h0003, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0, 1'b0, 16'h0003};
        tbl[1] = '{1'b1, 1'b0, 16'h0005, 1'b0, 1'b0, 16'h0007, 1'b1, 1'b0, 1'b0, 16'h0005};
        tbl[2] = '{1'b0, 1'b0, 16'h0001, 1'b1, 1'b0, 16'h0009, 1'b0, 1'b1, 1'b0, 16'h0009};
        tbl[3] = '{1'b0, 1'b0, 16'h0001, 1'b1, 1'b1, 16'h000A, 1'b0, 1'b1, 1'b1, 16'h000A};
        tbl[4] = '{1'b1, 1'b1, 16'h000B, 1'b0, 1'b1, 16'h000C, 1'b1, 1'b0, 1'b1, 16'h000B};
        tbl[5] = '{1'b1, 1'b0, 16'h0006, 1'b0, 1'b1, 16'h0007, 1'b1, 1'b0, 1'b0, 16'h0006};
        tbl[6] = '{1'b0, 1'b1, 16'h0042, 1'b0, 1'b0, 16'h0011, 1'b0, 1'b0, 1'b0, 16'h0042};

        // Reset state with requests pending
        idle();
        p0_req_valid = 1'b1; p0_req_addr = 16'h0010;
        p1_req_valid = 1'b1; p1_req_we = 1'b1; p1_req_addr = 16'h0004; p1_req_wstrb = 4'hF;
        rst_n = 1'b0;
        #1;
        chk("rst_p0_rsp_valid", p0_rsp_valid, 0);
        chk("rst_p1_rsp_valid", p1_rsp_valid, 0);
        chk("rst_p0_rsp_rdata", p0_rsp_rdata, 0);
        chk("rst_p1_rsp_rdata", p1_rsp_rdata, 0);
        chk("rst_p0_req_ready", p0_req_ready, 0);
        chk("rst_p1_req_ready", p1_req_ready, 0);
        chk("rst_ram_we", ram_we, 0);
        @(negedge clk);
        init_mem(32'd1);
        idle();
        rst_n = 1'b1;
        poke(8'h04, 32'hAABBCCDD);

        // Vector table: writes use wstrb=0, so memory contents are unchanged
        for (int i = 0; i < 7; i++) begin
            p0_req_valid = tbl[i].v0; p0_req_we = tbl[i].we0; p0_req_addr = tbl[i].a0;
            p0_req_wdata = 32'hFFFF_FFFF; p0_req_wstrb = 4'h0;
            p1_req_valid = tbl[i].v1; p1_req_we = tbl[i].we1; p1_req_addr = tbl[i].a1;
            p1_req_wdata = 32'hFFFF_FFFF; p1_req_wstrb = 4'h0;
            #1;
            chk($sformatf("tbl%0d_ready0", i), p0_req_ready, tbl[i].r0);
            chk($sformatf("tbl%0d_ready1", i), p1_req_ready, tbl[i].r1);
            chk($sformatf("tbl%0d_ram_we", i), ram_we, tbl[i].rwe);
            chk($sformatf("tbl%0d_ram_addr", i), ram_addr, tbl[i].raddr);
            tick();
        end
        idle(); tick(); tick();

        // Strobe write then read back
        p1_req_valid = 1'b1; p1_req_we = 1'b1; p1_req_addr = 16'h0004;
        p1_req_wdata = 32'h11223344; p1_req_wstrb = 4'b0101;
        #1;
        chk("strb_ready1", p1_req_ready, 1);
        chk("strb_ram_din", ram_din, 32'hAA22CC44);
        tick();
        model_mem[4] = 32'hAA22CC44;
        p1_req_we = 1'b0;
        #1;
        chk("strb_mem", ram_mem[4], 32'hAA22CC44);
        chk("strb_rd_ready1", p1_req_ready, 1);
        tick();
        idle();
        #1;
        chk("strb_rsp_valid", p1_rsp_valid, 1);
        chk("strb_rsp_rdata", p1_rsp_rdata, 32'hAA22CC44);
        tick();

        // Conflict: last grant was port 1
        p0_req_valid = 1'b1; p0_req_addr = 16'h0020;
        p1_req_valid = 1'b1; p1_req_addr = 16'h0021;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("conf%0d_ready0", c), p0_req_ready, (RR ? (c % 2 == 0) : 1'b1));
            chk($sformatf("conf%0d_ready1", c), p1_req_ready, (RR ? (c % 2 == 1) : 1'b0));
            tick();
        end
        idle(); tick();

        // Backpressure on port 0
        p0_rsp_ready = 1'b0;
        p0_req_valid = 1'b1; p0_req_addr = 16'h0030;
        #1 chk("bp_first_ready", p0_req_ready, 1);
        tick();
        p0_req_addr = 16'h0031;
        #1;
        chk("bp_second_blocked", p0_req_ready, 0);
        chk("bp_rsp_valid", p0_rsp_valid, 1);
        chk("bp_rsp_rdata", p0_rsp_rdata, model_mem[8'h30]);
        tick();
        #1;
        chk("bp_still_blocked", p0_req_ready, 0);
        chk("bp_held_rdata", p0_rsp_rdata, model_mem[8'h30]);
        p0_rsp_ready = 1'b1;
        #1 chk("bp_drain_accept", p0_req_ready, 1);
        tick();
        p0_req_valid = 1'b0;
        #1;
        chk("bp_second_valid", p0_rsp_valid, 1);
        chk("bp_second_rdata", p0_rsp_rdata, model_mem[8'h31]);
        tick();

        // Streaming reads 0..7
        for (int i = 0; i < 9; i++) begin
            p0_req_valid = (i < 8);
            p0_req_addr  = 16'(i);
            #1;
            if (i < 8) chk($sformatf("stream%0d_ready", i), p0_req_ready, 1);
            if (i > 0) begin
                chk($sformatf("stream%0d_valid", i), p0_rsp_valid, 1);
                chk($sformatf("stream%0d_rdata", i), p0_rsp_rdata, model_mem[i-1]);
            end
            tick();
        end
        #1 chk("stream_end_valid", p0_rsp_valid, 0);
        tick();

        // Write granted while port 0 read buffer is full
        p0_rsp_ready = 1'b0;
        p0_req_valid = 1'b1; p0_req_addr = 16'h0040;
        tick();
        p0_req_addr = 16'h0041;
        p1_req_valid = 1'b1; p1_req_we = 1'b1; p1_req_addr = 16'h0042;
        p1_req_wdata = 32'hDEADBEEF; p1_req_wstrb = 4'hF;
        #1;
        chk("mix_ready0", p0_req_ready, 0);
        chk("mix_ready1", p1_req_ready, 1);
        chk("mix_ram_we", ram_we, 1);
        chk("mix_ram_addr", ram_addr, 16'h0042);
        tick();
        model_mem[8'h42] = 32'hDEADBEEF;
        p1_req_valid = 1'b0; p1_req_we = 1'b0;
        #1 chk("mix_mem", ram_mem[8'h42], 32'hDEADBEEF);
        p0_rsp_ready = 1'b1;
        tick();
        idle(); tick(); tick();

        // Reset mid-cycle with a full buffer, a blocked read and a pending write
        p0_rsp_ready = 1'b0;
        p0_req_valid = 1'b1; p0_req_addr = 16'h0050;
        tick();
        p0_req_addr = 16'h0010;
        p1_req_valid = 1'b1; p1_req_we = 1'b1; p1_req_addr = 16'h0060;
        p1_req_wdata = 32'h12345678; p1_req_wstrb = 4'hF;
        #1;
        chk("mrst_pre_we", ram_we, 1);
        chk("mrst_pre_valid", p0_rsp_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("mrst_rsp_valid", p0_rsp_valid, 0);
        chk("mrst_rsp_rdata", p0_rsp_rdata, 0);
        chk("mrst_ram_we", ram_we, 0);
        chk("mrst_ready0", p0_req_ready, 0);
        chk("mrst_ready1", p1_req_ready, 0);
        tick();
        p1_req_valid = 1'b0; p1_req_we = 1'b0;
        p0_rsp_ready = 1'b1;
        rst_n = 1'b1;
        #1;
        chk("mrst_after_ready0", p0_req_ready, 1);
        chk("mrst_no_write", ram_mem[8'h60], model_mem[8'h60]);
        tick();
        p0_req_valid = 1'b0;
        #1;
        chk("mrst_after_valid", p0_rsp_valid, 1);
        chk("mrst_after_rdata", p0_rsp_rdata, model_mem[8'h10]);
        tick();

        // Randomized run against the reference model, from a fresh reset
        idle();
        rst_n = 1'b0;
        tick();
        init_mem(32'h0000_0007);
        rst_n = 1'b1;
        q0.delete(); q1.delete();
        model_last = 1;
        for (int n = 0; n < 2; n++) begin pv[n] = 1'b0; acc[n] = 1'b0; end
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int n = 0; n < 2; n++) begin
                if (!pv[n] || acc[n]) begin
                    pv[n] = ($urandom_range(0, 3) != 0);
                    pw[n] = ($urandom_range(0, 2) == 0);
                    pa[n] = 16'($urandom_range(0, 15));
                    pd[n] = $urandom;
                    ps[n] = 4'($urandom_range(0, 15));
                end
                rr[n] = ($urandom_range(0, 2) != 0);
            end
            p0_req_valid = pv[0]; p0_req_we = pw[0]; p0_req_addr = pa[0];
            p0_req_wdata = pd[0]; p0_req_wstrb = ps[0]; p0_rsp_ready = rr[0];
            p1_req_valid = pv[1]; p1_req_we = pw[1]; p1_req_addr = pa[1];
            p1_req_wdata = pd[1]; p1_req_wstrb = ps[1]; p1_rsp_ready = rr[1];
            #1;
            el[0] = pv[0] && (pw[0] || q0.size() == 0 || rr[0]);
            el[1] = pv[1] && (pw[1] || q1.size() == 0 || rr[1]);
            if (el[0] && el[1]) g = (RR && model_last == 0) ? 1 : 0;
            else if (el[0]) g = 0;
            else if (el[1]) g = 1;
            else g = -1;
            chk("rnd_ready0", p0_req_ready, (g == 0));
            chk("rnd_ready1", p1_req_ready, (g == 1));
            chk("rnd_ram_we", ram_we, (g >= 0) ? pw[g] : 1'b0);
            chk("rnd_ram_addr", ram_addr, (g >= 0) ? pa[g] : pa[0]);
            if (g >= 0 && pw[g])
                chk("rnd_ram_din", ram_din, merge(pd[g], model_mem[pa[g][7:0]], ps[g]));
            chk("rnd_p0_rsp_valid", p0_rsp_valid, (q0.size() != 0));
            if (q0.size() != 0) chk("rnd_p0_rdata", p0_rsp_rdata, q0[0]);
            chk("rnd_p1_rsp_valid", p1_rsp_valid, (q1.size() != 0));
            if (q1.size() != 0) chk("rnd_p1_rdata", p1_rsp_rdata, q1[0]);
            if (rr[0] && q0.size() != 0) void'(q0.pop_front());
            if (rr[1] && q1.size() != 0) void'(q1.pop_front());
            if (g >= 0) begin
                mdat = model_mem[pa[g][7:0]];
                if (pw[g]) model_mem[pa[g][7:0]] = merge(pd[g], mdat, ps[g]);
                else if (g == 0) q0.push_back(mdat);
                else q1.push_back(mdat);
                model_last = g;
            end
            acc[0] = (g == 0);
            acc[1] = (g == 1);
            tick();
        end
        idle();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
